// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared types and default geometry for the VGA scanout blocks.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  // Line-fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOST  = 2'd2
  } fetch_state_t;

  // Default 640x576 geometry, 12-bit RGB 4:4:4 pixels
  localparam int C_H_DISP = 640;
  localparam int C_V_DISP = 576;
  localparam int C_ADDR_W = 19;
  localparam int C_DATA_W = 12;
  localparam int C_LINE_W = 12;

endpackage
`default_nettype wire

// File: rtl/vga_line_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_line_fetch_if                                                    |
// | Shared pixel-memory port plus the host write request channel.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vga_line_fetch_if #(
  parameter int addr_w = vga_pkg::C_ADDR_W,
  parameter int data_w = vga_pkg::C_DATA_W
);
  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [addr_w-1:0] mem_addr;
  logic [data_w-1:0] mem_wdata;
  logic              mem_ack;
  logic [data_w-1:0] mem_rdata;
  // Host write channel
  logic              host_req;
  logic [addr_w-1:0] host_addr;
  logic [data_w-1:0] host_data;
  logic              host_gnt;

  // Controller view: drives the memory, serves the host
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, host_gnt,
    input  mem_ack, mem_rdata, host_req, host_addr, host_data
  );

  // Environment view: memory plus host writer
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, host_gnt,
    output mem_ack, mem_rdata, host_req, host_addr, host_data
  );
endinterface
`default_nettype wire

// File: rtl/vga_fetch_addr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fetch_addr                                                       |
// | Line base multiply, pixel counter and last-pixel detection.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_fetch_addr
  import vga_pkg::*;
#(
  parameter int h_disp = C_H_DISP,
  parameter int addr_w = C_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [C_LINE_W-1:0] load_y,
  input  logic                adv,
  output logic [C_LINE_W-1:0] x,
  output logic                last,
  output logic [addr_w-1:0]   addr_nxt
);

  logic [addr_w-1:0]   r_base;
  logic [C_LINE_W-1:0] r_x;
  logic [addr_w-1:0]   w_prod;
  logic [addr_w-1:0]   w_cur;

  // Line base is computed at address width; upper bits simply wrap
  assign w_prod = addr_w'(load_y) * addr_w'(h_disp);
  assign w_cur  = r_base + addr_w'(r_x);
  assign x      = r_x;
  assign last   = (r_x == C_LINE_W'(h_disp - 1));

  // Address the memory will see next cycle, so the top can register it
  always_comb begin
    addr_nxt = w_cur;
    if (load) begin
      addr_nxt = w_prod;
    end else if (adv) begin
      addr_nxt = w_cur + addr_w'(1);
    end
  end

  // Base and pixel counter; a load always restarts the line at x=0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= '0;
      r_x    <= '0;
    end else if (load) begin
      r_base <= w_prod;
      r_x    <= '0;
    end else if (adv) begin
      r_x    <= r_x + C_LINE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_line_fetch                                                       |
// | Per-line prefetch into the display line buffer, arbitrating the     |
// | single-port pixel memory with a lower-priority host writer.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int h_disp = C_H_DISP,
  parameter int v_disp = C_V_DISP,
  parameter int addr_w = C_ADDR_W,
  parameter int data_w = C_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                line_start,
  input  logic [C_LINE_W-1:0] line_y,
  vga_line_fetch_if.master    bus,
  output logic                lb_we,
  output logic [C_LINE_W-1:0] lb_addr,
  output logic [data_w-1:0]   lb_wdata,
  output logic                fetch_busy,
  output logic                underrun
);

  fetch_state_t        r_st;
  fetch_state_t        w_nxt_st;
  logic                r_pend;
  logic [C_LINE_W-1:0] r_pend_y;
  logic                w_start_ok;
  logic                w_pend;
  logic [C_LINE_W-1:0] w_pend_y;
  logic                w_ack;
  logic                w_load;
  logic                w_adv;
  logic                w_take_host;
  logic [C_LINE_W-1:0] w_x;
  logic                w_last;
  logic [addr_w-1:0]   w_addr_nxt;
  logic [addr_w-1:0]   w_mem_addr_d;
  logic [data_w-1:0]   w_mem_wdata_d;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [addr_w-1:0]   r_mem_addr;
  logic [data_w-1:0]   r_mem_wdata;
  logic                r_host_gnt;
  logic                r_lb_we;
  logic [C_LINE_W-1:0] r_lb_addr;
  logic [data_w-1:0]   r_lb_wdata;
  logic                r_fetch_busy;
  logic                r_underrun;

  // Off-screen lines never become pending; the newest valid line wins
  assign w_start_ok = line_start && (32'(line_y) < v_disp);
  assign w_pend     = r_pend | w_start_ok;
  assign w_pend_y   = w_start_ok ? line_y : r_pend_y;
  assign w_ack      = r_mem_req & bus.mem_ack;

  vga_fetch_addr #(
    .h_disp (h_disp),
    .addr_w (addr_w)
  ) u_addr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_y   (w_pend_y),
    .adv      (w_adv),
    .x        (w_x),
    .last     (w_last),
    .addr_nxt (w_addr_nxt)
  );

  // Next state: fetch beats host; a new line abandons the current one
  always_comb begin
    w_nxt_st    = r_st;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_take_host = 1'b0;
    case (r_st)
      ST_IDLE: begin
        if (w_pend) begin
          w_nxt_st = ST_FETCH;
          w_load   = 1'b1;
        end else if (bus.host_req) begin
          w_nxt_st    = ST_HOST;
          w_take_host = 1'b1;
        end
      end
      ST_FETCH: begin
        if (w_ack) begin
          if (w_pend) begin
            w_load = 1'b1;
          end else if (w_last) begin
            w_nxt_st = ST_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      ST_HOST: begin
        if (w_ack) begin
          w_nxt_st = ST_IDLE;
        end
      end
      default: w_nxt_st = ST_IDLE;
    endcase
  end

  // Next memory address/data: fetch address, or the host pair held for the write
  always_comb begin
    w_mem_addr_d  = '0;
    w_mem_wdata_d = '0;
    case (w_nxt_st)
      ST_FETCH: w_mem_addr_d = w_addr_nxt;
      ST_HOST: begin
        if (w_take_host) begin
          w_mem_addr_d  = bus.host_addr;
          w_mem_wdata_d = bus.host_data;
        end else begin
          w_mem_addr_d  = r_mem_addr;
          w_mem_wdata_d = r_mem_wdata;
        end
      end
      default: ;
    endcase
  end

  // State register and pending-line capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st     <= ST_IDLE;
      r_pend   <= 1'b0;
      r_pend_y <= '0;
    end else begin
      r_st     <= w_nxt_st;
      r_pend   <= w_pend & ~w_load;
      r_pend_y <= w_pend_y;
    end
  end

  // Registered memory port, grant, status and line-buffer outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_host_gnt   <= 1'b0;
      r_lb_we      <= 1'b0;
      r_lb_addr    <= '0;
      r_lb_wdata   <= '0;
      r_fetch_busy <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_mem_req    <= (w_nxt_st != ST_IDLE);
      r_mem_we     <= (w_nxt_st == ST_HOST);
      r_mem_addr   <= w_mem_addr_d;
      r_mem_wdata  <= w_mem_wdata_d;
      r_host_gnt   <= (r_st == ST_HOST) && w_ack;
      r_fetch_busy <= (w_nxt_st == ST_FETCH);
      r_underrun   <= (r_st == ST_FETCH) && line_start;
      r_lb_we      <= (r_st == ST_FETCH) && w_ack;
      if ((r_st == ST_FETCH) && w_ack) begin
        r_lb_addr  <= w_x;
        r_lb_wdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.host_gnt  = r_host_gnt;
  assign lb_we         = r_lb_we;
  assign lb_addr       = r_lb_addr;
  assign lb_wdata      = r_lb_wdata;
  assign fetch_busy    = r_fetch_busy;
  assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_line_fetch                                                    |
// | Directed scenarios with randomized data, ack timing and addresses;  |
// | a transfer-order scoreboard predicts memory and line-buffer traffic.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_line_fetch;
  localparam int HD = 640;
  localparam int VD = 576;
  localparam int AW = 19;
  localparam int DW = 12;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            x;
  } xfer_t;

  typedef struct {
    int            x;
    logic [DW-1:0] d;
  } lbx_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          line_start = 1'b0;
  logic [11:0]   line_y = '0;
  logic          lb_we;
  logic [11:0]   lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          fetch_busy;
  logic          underrun;

  vga_line_fetch_if #(.addr_w(AW), .data_w(DW)) bus_if ();

  vga_line_fetch #(.h_disp(HD), .v_disp(VD), .addr_w(AW), .data_w(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .line_y     (line_y),
    .bus        (bus_if),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_wdata   (lb_wdata),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  xfer_t       exp_q[$];
  lbx_t        lb_q[$];
  int          total = 0;
  int          bad = 0;
  int          ack_mode = 0;
  int          ack_delay = 0;
  int          ack_wait = 0;
  int          busy_cnt = 0;
  int          gnt_cnt = 0;
  int          unr_cnt = 0;
  logic [31:0] seed_w = 32'd0;

  // Pixel memory contents: a seeded hash of the address
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    logic [31:0] v;
    v = (32'(a) * 32'd40503) ^ seed_w;
    v = v ^ (v >> 11);
    return v[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // A full or partial line read, in pixel order
  task automatic queue_line(input int y, input int n);
    xfer_t t;
    for (int i = 0; i < n; i++) begin
      t.we = 1'b0; t.addr = AW'(y * HD + i); t.wdata = '0; t.x = i;
      exp_q.push_back(t);
    end
  endtask

  task automatic queue_host(input logic [AW-1:0] a, input logic [DW-1:0] d);
    xfer_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d; t.x = 0;
    exp_q.push_back(t);
  endtask

  // One clock: observe outputs at the falling edge, then drive the memory response
  task automatic cyc();
    logic  ack;
    xfer_t t;
    lbx_t  e;
    @(negedge clk);
    line_start = 1'b0;
    if (fetch_busy) busy_cnt++;
    if (underrun) unr_cnt++;
    if (bus_if.host_gnt) begin
      gnt_cnt++;
      bus_if.host_req = 1'b0;
    end
    if (lb_we) begin
      if (lb_q.size() == 0) begin
        check("lb_extra", 32'd1, 32'd0);
      end else begin
        e = lb_q.pop_front();
        check("lb_addr", 32'(lb_addr), 32'(e.x));
        check("lb_wdata", 32'(lb_wdata), 32'(e.d));
      end
    end
    if (ack_mode == 0) begin
      ack = 1'b1;
    end else if (ack_mode == 1) begin
      ack = 1'($urandom_range(0, 1));
    end else if (bus_if.mem_req) begin
      ack = (ack_wait == ack_delay);
      ack_wait = ack ? 0 : ack_wait + 1;
    end else begin
      ack = 1'b0;
      ack_wait = 0;
    end
    bus_if.mem_ack   = ack;
    bus_if.mem_rdata = ack ? pix(bus_if.mem_addr) : DW'($urandom);
    if (bus_if.mem_req && ack) begin
      if (exp_q.size() == 0) begin
        check("mem_extra", 32'd1, 32'd0);
      end else begin
        t = exp_q.pop_front();
        check("mem_we", 32'(bus_if.mem_we), 32'(t.we));
        check("mem_addr", 32'(bus_if.mem_addr), 32'(t.addr));
        if (t.we) begin
          check("mem_wdata", 32'(bus_if.mem_wdata), 32'(t.wdata));
        end else begin
          e.x = t.x; e.d = pix(t.addr);
          lb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((fetch_busy || bus_if.mem_req) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    repeat (3) cyc();
    check({tag, "_leftover"}, 32'(exp_q.size() + lb_q.size()), 32'd0);
  endtask

  task automatic wait_gnt(input string tag, input int budget);
    int n;
    int g0;
    n = 0;
    g0 = gnt_cnt;
    while (gnt_cnt == g0 && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int            y;
    int            n;
    int            u0;
    int            g0;
    int            req_seen;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;

    seed_w           = $urandom;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = '0;
    bus_if.host_req  = 1'b0;
    bus_if.host_addr = '0;
    bus_if.host_data = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus_if.mem_wdata), 32'd0);
    check("rst_host_gnt", 32'(bus_if.host_gnt), 32'd0);
    check("rst_lb_we", 32'(lb_we), 32'd0);
    check("rst_lb_addr", 32'(lb_addr), 32'd0);
    check("rst_lb_wdata", 32'(lb_wdata), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Full line 2 at one pixel per clock
    ack_mode = 0;
    queue_line(2, HD);
    busy_cnt = 0;
    line_start = 1'b1; line_y = 12'd2;
    cyc();
    check("l2_first_req", 32'(bus_if.mem_req), 32'd1);
    check("l2_first_addr", 32'(bus_if.mem_addr), 32'd1280);
    check("l2_first_busy", 32'(fetch_busy), 32'd1);
    run_until_idle("l2", 2000);
    check("l2_busy_cycles", 32'(busy_cnt), 32'(HD));

    // Single host write in IDLE
    g0 = gnt_cnt;
    queue_host(AW'(32'h100), DW'(32'hABC));
    bus_if.host_req = 1'b1; bus_if.host_addr = AW'(32'h100); bus_if.host_data = DW'(32'hABC);
    wait_gnt("host1", 50);
    repeat (3) cyc();
    check("host1_gnt_count", 32'(gnt_cnt - g0), 32'd1);
    check("host1_idle_req", 32'(bus_if.mem_req), 32'd0);
    check("host1_leftover", 32'(exp_q.size()), 32'd0);

    // Host request and line start together: the fetch goes first
    ack_mode = 1;
    y  = $urandom_range(0, VD - 1);
    ha = AW'($urandom); hd = DW'($urandom);
    queue_line(y, HD);
    queue_host(ha, hd);
    bus_if.host_req = 1'b1; bus_if.host_addr = ha; bus_if.host_data = hd;
    line_start = 1'b1; line_y = 12'(y);
    wait_gnt("tie", 6000);
    repeat (3) cyc();
    check("tie_leftover", 32'(exp_q.size() + lb_q.size()), 32'd0);

    // Line start while a slow host write is in flight
    ack_mode = 2; ack_delay = 5; ack_wait = 0;
    u0 = unr_cnt;
    ha = AW'($urandom); hd = DW'($urandom);
    y  = $urandom_range(0, VD - 1);
    queue_host(ha, hd);
    queue_line(y, HD);
    bus_if.host_req = 1'b1; bus_if.host_addr = ha; bus_if.host_data = hd;
    n = 0;
    cyc();
    while (!(bus_if.mem_req && bus_if.mem_we) && n < 20) begin
      cyc();
      n++;
    end
    check("hl_host_start_timeout", 32'(n < 20), 32'd1);
    line_start = 1'b1; line_y = 12'(y);
    wait_gnt("hl", 50);
    check("hl_gnt_cycle_req", 32'(bus_if.mem_req), 32'd0);
    cyc();
    check("hl_fetch_req", 32'(bus_if.mem_req), 32'd1);
    check("hl_fetch_we", 32'(bus_if.mem_we), 32'd0);
    check("hl_fetch_addr", 32'(bus_if.mem_addr), 32'(AW'(y * HD)));
    run_until_idle("hl", 6000);
    check("hl_no_underrun", 32'(unr_cnt - u0), 32'd0);

    // Second line start at x=300 abandons line 2 and restarts on line 3
    ack_mode = 0;
    u0 = unr_cnt;
    queue_line(2, 301);
    queue_line(3, HD);
    line_start = 1'b1; line_y = 12'd2;
    n = 0;
    cyc();
    while (!(bus_if.mem_req && bus_if.mem_ack && bus_if.mem_addr == AW'(2 * HD + 300)) && n < 1000) begin
      cyc();
      n++;
    end
    check("ur_reach_x300_timeout", 32'(n < 1000), 32'd1);
    line_start = 1'b1; line_y = 12'd3;
    cyc();
    check("ur_restart_addr", 32'(bus_if.mem_addr), 32'd1920);
    check("ur_pulse_now", 32'(underrun), 32'd1);
    run_until_idle("ur", 2000);
    check("ur_pulse_count", 32'(unr_cnt - u0), 32'd1);

    // Off-screen line: nothing fetched, host still served
    line_start = 1'b1; line_y = 12'($urandom_range(VD, 4095));
    req_seen = 0;
    repeat (6) begin
      cyc();
      if (bus_if.mem_req || fetch_busy) req_seen++;
    end
    check("offscreen_no_req", 32'(req_seen), 32'd0);
    g0 = gnt_cnt;
    ha = AW'($urandom); hd = DW'($urandom);
    queue_host(ha, hd);
    bus_if.host_req = 1'b1; bus_if.host_addr = ha; bus_if.host_data = hd;
    wait_gnt("offscreen_host", 50);
    check("offscreen_gnt", 32'(gnt_cnt - g0), 32'd1);

    // Random lines with random ack gaps
    ack_mode = 1;
    for (int r = 0; r < 2; r++) begin
      y = $urandom_range(0, VD - 1);
      queue_line(y, HD);
      line_start = 1'b1; line_y = 12'(y);
      cyc();
      run_until_idle("rand", 6000);
    end

    // Reset in mid-fetch drops the request at once and loses the line
    ack_mode = 0;
    y = $urandom_range(0, VD - 1);
    queue_line(y, HD);
    line_start = 1'b1; line_y = 12'(y);
    repeat (50) cyc();
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_if.mem_req), 32'd0);
    check("mid_rst_busy", 32'(fetch_busy), 32'd0);
    check("mid_rst_lb_we", 32'(lb_we), 32'd0);
    exp_q.delete();
    lb_q.delete();
    repeat (2) cyc();
    reset_n = 1'b1;
    req_seen = 0;
    repeat (10) begin
      cyc();
      if (bus_if.mem_req || fetch_busy) req_seen++;
    end
    check("post_rst_quiet", 32'(req_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
